// File: rtl/vga_box_renderer.sv
// Draws NBOX double-buffered filled rectangles over the vga640x480 timing stream, 2-strobe pipeline.
// Optional outline-only boxes are built when VGA_BOX_OUTLINE_EN is defined.
module vga_box_renderer #(
  parameter int       NBOX     = 4,
  parameter int       X_W      = 10,
  parameter int       Y_W      = 9,
  parameter logic     SYNC_POL = 1'b0,
  parameter int       IDX_W    = (NBOX > 1) ? $clog2(NBOX) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_active,
  input  logic [X_W-1:0]   i_x,
  input  logic [Y_W-1:0]   i_y,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [X_W-1:0]   i_wr_x0,
  input  logic [X_W-1:0]   i_wr_x1,
  input  logic [Y_W-1:0]   i_wr_y0,
  input  logic [Y_W-1:0]   i_wr_y1,
  input  logic [11:0]      i_wr_rgb,
  input  logic             i_wr_en,
  input  logic             i_wr_outline,
  input  logic             i_commit,
  output logic             o_pending,
  output logic             o_hs,
  output logic             o_vs,
  output logic [3:0]       o_r,
  output logic [3:0]       o_g,
  output logic [3:0]       o_b
);

  localparam logic [IDX_W:0] NBOX_L = (IDX_W+1)'(NBOX);
  localparam logic [X_W-1:0] X_ONE  = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE  = {{(Y_W-1){1'b0}}, 1'b1};

  logic [X_W-1:0] r_sh_x0 [NBOX];
  logic [X_W-1:0] r_sh_x1 [NBOX];
  logic [Y_W-1:0] r_sh_y0 [NBOX];
  logic [Y_W-1:0] r_sh_y1 [NBOX];
  logic [11:0]    r_sh_rgb [NBOX];
  logic [NBOX-1:0] r_sh_en;

  logic [X_W-1:0] r_ac_x0 [NBOX];
  logic [X_W-1:0] r_ac_x1 [NBOX];
  logic [Y_W-1:0] r_ac_y0 [NBOX];
  logic [Y_W-1:0] r_ac_y1 [NBOX];
  logic [11:0]    r_ac_rgb [NBOX];
  logic [NBOX-1:0] r_ac_en;

`ifdef VGA_BOX_OUTLINE_EN
  logic [NBOX-1:0] r_sh_ol;
  logic [NBOX-1:0] r_ac_ol;
`else
  logic w_unused_outline;
  assign w_unused_outline = i_wr_outline;
`endif

  logic r_pending;
  logic r_vs_prev;
  logic w_wr_fire;
  logic w_boundary;

  assign o_wr_ready = ~r_pending;
  assign o_pending  = r_pending;
  assign w_wr_fire  = i_wr_valid & ~r_pending;
  assign w_boundary = i_pix_stb & (i_vs == SYNC_POL) & (r_vs_prev == ~SYNC_POL);

  // Shadow/active register sets and the commit handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_vs_prev <= ~SYNC_POL;
      r_sh_en   <= '0;
      r_ac_en   <= '0;
`ifdef VGA_BOX_OUTLINE_EN
      r_sh_ol   <= '0;
      r_ac_ol   <= '0;
`endif
      for (int i = 0; i < NBOX; i++) begin
        r_sh_x0[i]  <= '0;
        r_sh_x1[i]  <= '0;
        r_sh_y0[i]  <= '0;
        r_sh_y1[i]  <= '0;
        r_sh_rgb[i] <= '0;
        r_ac_x0[i]  <= '0;
        r_ac_x1[i]  <= '0;
        r_ac_y0[i]  <= '0;
        r_ac_y1[i]  <= '0;
        r_ac_rgb[i] <= '0;
      end
    end else begin
      if (i_pix_stb) r_vs_prev <= i_vs;

      if (w_wr_fire && ({1'b0, i_wr_idx} < NBOX_L)) begin
        r_sh_x0[i_wr_idx]  <= i_wr_x0;
        r_sh_x1[i_wr_idx]  <= i_wr_x1;
        r_sh_y0[i_wr_idx]  <= i_wr_y0;
        r_sh_y1[i_wr_idx]  <= i_wr_y1;
        r_sh_rgb[i_wr_idx] <= i_wr_rgb;
        r_sh_en[i_wr_idx]  <= i_wr_en;
`ifdef VGA_BOX_OUTLINE_EN
        r_sh_ol[i_wr_idx]  <= i_wr_outline;
`endif
      end

      // Writes are blocked while pending, so the copy never races a shadow update.
      if (w_boundary && r_pending) begin
        r_ac_x0   <= r_sh_x0;
        r_ac_x1   <= r_sh_x1;
        r_ac_y0   <= r_sh_y0;
        r_ac_y1   <= r_sh_y1;
        r_ac_rgb  <= r_sh_rgb;
        r_ac_en   <= r_sh_en;
`ifdef VGA_BOX_OUTLINE_EN
        r_ac_ol   <= r_sh_ol;
`endif
        r_pending <= 1'b0;
      end else if (i_commit && !r_pending) begin
        r_pending <= 1'b1;
      end
    end
  end

  logic [NBOX-1:0] w_hit;

  for (genvar g = 0; g < NBOX; g++) begin : g_hit
    logic w_inside;
    assign w_inside = r_ac_en[g] &
                      (i_x > r_ac_x0[g]) & (i_x < r_ac_x1[g]) &
                      (i_y > r_ac_y0[g]) & (i_y < r_ac_y1[g]);
`ifdef VGA_BOX_OUTLINE_EN
    logic w_rim;
    assign w_rim = (i_x == r_ac_x0[g] + X_ONE) | (i_x == r_ac_x1[g] - X_ONE) |
                   (i_y == r_ac_y0[g] + Y_ONE) | (i_y == r_ac_y1[g] - Y_ONE);
    assign w_hit[g] = w_inside & (~r_ac_ol[g] | w_rim);
`else
    assign w_hit[g] = w_inside;
`endif
  end

  logic [NBOX-1:0] r_s1_hit;
  logic            r_s1_active;
  logic            r_s1_hs;
  logic            r_s1_vs;
  logic [11:0]     w_rgb_sel;
  logic [11:0]     r_s2_rgb;
  logic            r_s2_hs;
  logic            r_s2_vs;

  // Scan from the highest index down so the lowest hitting index wins.
  always_comb begin
    w_rgb_sel = '0;
    for (int i = NBOX - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) w_rgb_sel = r_ac_rgb[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_hit    <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= ~SYNC_POL;
      r_s1_vs     <= ~SYNC_POL;
      r_s2_rgb    <= '0;
      r_s2_hs     <= ~SYNC_POL;
      r_s2_vs     <= ~SYNC_POL;
    end else if (i_pix_stb) begin
      r_s1_hit    <= w_hit;
      r_s1_active <= i_active;
      r_s1_hs     <= i_hs;
      r_s1_vs     <= i_vs;
      r_s2_rgb    <= r_s1_active ? w_rgb_sel : 12'h000;
      r_s2_hs     <= r_s1_hs;
      r_s2_vs     <= r_s1_vs;
    end
  end

  assign o_r  = r_s2_rgb[11:8];
  assign o_g  = r_s2_rgb[7:4];
  assign o_b  = r_s2_rgb[3:0];
  assign o_hs = r_s2_hs;
  assign o_vs = r_s2_vs;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: commit timing, priority, latency, stalls, reset.
// Honours VGA_BOX_OUTLINE_EN for the outline expectations.
module tb_vga_box_renderer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_pix_stb = 1'b0;
  logic        i_hs = 1'b1;
  logic        i_vs = 1'b1;
  logic        i_active = 1'b0;
  logic [9:0]  i_x = '0;
  logic [8:0]  i_y = '0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [1:0]  i_wr_idx = '0;
  logic [9:0]  i_wr_x0 = '0;
  logic [9:0]  i_wr_x1 = '0;
  logic [8:0]  i_wr_y0 = '0;
  logic [8:0]  i_wr_y1 = '0;
  logic [11:0] i_wr_rgb = '0;
  logic        i_wr_en = 1'b0;
  logic        i_wr_outline = 1'b0;
  logic        i_commit = 1'b0;
  logic        o_pending;
  logic        o_hs;
  logic        o_vs;
  logic [3:0]  o_r;
  logic [3:0]  o_g;
  logic [3:0]  o_b;

  int n_checks = 0;
  int n_errors = 0;

  vga_box_renderer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
    .i_hs(i_hs), .i_vs(i_vs), .i_active(i_active), .i_x(i_x), .i_y(i_y),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_idx(i_wr_idx),
    .i_wr_x0(i_wr_x0), .i_wr_x1(i_wr_x1), .i_wr_y0(i_wr_y0), .i_wr_y1(i_wr_y1),
    .i_wr_rgb(i_wr_rgb), .i_wr_en(i_wr_en), .i_wr_outline(i_wr_outline),
    .i_commit(i_commit), .o_pending(o_pending),
    .o_hs(o_hs), .o_vs(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  always #5 i_clk = ~i_clk;

  task automatic step(input logic [9:0] x, input logic [8:0] y,
                      input logic act, input logic hs, input logic vs);
    i_x = x; i_y = y; i_active = act; i_hs = hs; i_vs = vs; i_pix_stb = 1'b1;
    @(posedge i_clk); #1;
    i_pix_stb = 1'b0;
  endtask

  task automatic probe(input logic [9:0] x, input logic [8:0] y, output logic [11:0] rgb);
    step(x, y, 1'b1, 1'b1, 1'b1);
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    rgb = {o_r, o_g, o_b};
  endtask

  task automatic frame_edge();
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic set_wr(input logic [1:0] idx, input logic [9:0] x0, input logic [8:0] y0,
                        input logic [9:0] x1, input logic [8:0] y1, input logic [11:0] rgb,
                        input logic en, input logic ol);
    i_wr_idx = idx; i_wr_x0 = x0; i_wr_y0 = y0; i_wr_x1 = x1; i_wr_y1 = y1;
    i_wr_rgb = rgb; i_wr_en = en; i_wr_outline = ol;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [9:0] x0, input logic [8:0] y0,
                    input logic [9:0] x1, input logic [8:0] y1, input logic [11:0] rgb,
                    input logic en, input logic ol);
    bit done = 0;
    set_wr(idx, x0, y0, x1, y1, rgb, en, ol);
    i_wr_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (o_wr_ready) done = 1;
      @(posedge i_clk); #1;
    end
    i_wr_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL wr_accept idx=%0d: ready never seen within 20 cycles", idx);
    end
  endtask

  task automatic commit();
    i_commit = 1'b1;
    @(posedge i_clk); #1;
    i_commit = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] rgb;
    i_rst = 1'b1; i_pix_stb = 1'b1; i_active = 1'b1; i_hs = 1'b0; i_vs = 1'b0;
    i_x = 10'd300; i_y = 9'd200;
    repeat (3) @(posedge i_clk);
    #1; i_rst = 1'b0; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
    n_checks++;
    if ({o_r, o_g, o_b, o_hs, o_vs, o_pending, o_wr_ready} !== {12'h000, 4'b1101}) begin
      n_errors++;
      $display("FAIL reset_outputs got rgb=%h hs=%b vs=%b pend=%b rdy=%b want 000 1 1 0 1",
               {o_r, o_g, o_b}, o_hs, o_vs, o_pending, o_wr_ready);
    end
    probe(10'd300, 9'd200, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin
      n_errors++; $display("FAIL reset_blank got %h want 000", rgb);
    end
  endtask

  task automatic test_commit_single();
    logic [11:0] rgb;
    wr(2'd0, 10'd120, 9'd40, 10'd280, 9'd200, 12'h0F0, 1'b1, 1'b0);
    commit();
    n_checks++;
    if (o_pending !== 1'b1) begin n_errors++; $display("FAIL commit_pending got %b want 1", o_pending); end
    probe(10'd121, 9'd41, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL pre_publish got %h want 000", rgb); end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (o_pending !== 1'b1) begin n_errors++; $display("FAIL pending_before_vs got %b want 1", o_pending); end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (o_pending !== 1'b0 || o_wr_ready !== 1'b1) begin
      n_errors++; $display("FAIL pending_at_vs got pend=%b rdy=%b want 0 1", o_pending, o_wr_ready);
    end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    probe(10'd121, 9'd41, rgb);
    n_checks++;
    if (rgb !== 12'h0F0) begin n_errors++; $display("FAIL inner_corner got %h want 0F0", rgb); end
    probe(10'd120, 9'd41, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL left_edge got %h want 000", rgb); end
    probe(10'd279, 9'd199, rgb);
    n_checks++;
    if (rgb !== 12'h0F0) begin n_errors++; $display("FAIL far_corner got %h want 0F0", rgb); end
    probe(10'd279, 9'd200, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL bottom_edge got %h want 000", rgb); end
    probe(10'd121, 9'd41, rgb);
    step(10'd121, 9'd41, 1'b0, 1'b1, 1'b1);
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({o_r, o_g, o_b} !== 12'h000) begin
      n_errors++; $display("FAIL inactive_blank got %h want 000", {o_r, o_g, o_b});
    end
  endtask

  task automatic test_latency();
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    step(10'd150, 9'd100, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({o_r, o_g, o_b, o_hs} !== {12'h000, 1'b1}) begin
      n_errors++; $display("FAIL latency_1 got rgb=%h hs=%b want 000 1", {o_r, o_g, o_b}, o_hs);
    end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({o_r, o_g, o_b, o_hs} !== {12'h0F0, 1'b0}) begin
      n_errors++; $display("FAIL latency_2 got rgb=%h hs=%b want 0F0 0", {o_r, o_g, o_b}, o_hs);
    end
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_r, o_g, o_b, o_hs} !== {12'h0F0, 1'b0}) begin
      n_errors++; $display("FAIL stall_hold got rgb=%h hs=%b want 0F0 0", {o_r, o_g, o_b}, o_hs);
    end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({o_r, o_g, o_b, o_hs} !== {12'h000, 1'b1}) begin
      n_errors++; $display("FAIL latency_3 got rgb=%h hs=%b want 000 1", {o_r, o_g, o_b}, o_hs);
    end
  endtask

  task automatic test_priority();
    logic [11:0] rgb;
    wr(2'd0, 10'd200, 9'd120, 10'd360, 9'd280, 12'hF00, 1'b1, 1'b0);
    wr(2'd1, 10'd280, 9'd200, 10'd440, 9'd360, 12'h00F, 1'b1, 1'b0);
    wr(2'd2, 10'd10, 9'd10, 10'd11, 9'd30, 12'hFFF, 1'b1, 1'b0);
    wr(2'd3, 10'd0, 9'd0, 10'd639, 9'd479, 12'h123, 1'b0, 1'b0);
    commit();
    frame_edge();
    probe(10'd300, 9'd250, rgb);
    n_checks++;
    if (rgb !== 12'hF00) begin n_errors++; $display("FAIL overlap_prio got %h want F00", rgb); end
    probe(10'd400, 9'd300, rgb);
    n_checks++;
    if (rgb !== 12'h00F) begin n_errors++; $display("FAIL box1_only got %h want 00F", rgb); end
    probe(10'd500, 9'd300, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL disabled_box got %h want 000", rgb); end
    probe(10'd11, 9'd15, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL thin_box got %h want 000", rgb); end
  endtask

  task automatic test_stall_write();
    logic [11:0] rgb;
    wr(2'd2, 10'd500, 9'd400, 10'd600, 9'd470, 12'h0FF, 1'b1, 1'b0);
    commit();
    set_wr(2'd0, 10'd200, 9'd120, 10'd360, 9'd280, 12'h0F0, 1'b1, 1'b0);
    i_wr_valid = 1'b1;
    probe(10'd550, 9'd450, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL midframe_unchanged got %h want 000", rgb); end
    n_checks++;
    if (o_wr_ready !== 1'b0) begin n_errors++; $display("FAIL ready_stalled got %b want 0", o_wr_ready); end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (o_wr_ready !== 1'b1) begin n_errors++; $display("FAIL ready_return got %b want 1", o_wr_ready); end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    i_wr_valid = 1'b0;
    probe(10'd550, 9'd450, rgb);
    n_checks++;
    if (rgb !== 12'h0FF) begin n_errors++; $display("FAIL new_frame_box got %h want 0FF", rgb); end
    probe(10'd300, 9'd250, rgb);
    n_checks++;
    if (rgb !== 12'hF00) begin n_errors++; $display("FAIL stalled_not_live got %h want F00", rgb); end
    commit();
    frame_edge();
    probe(10'd300, 9'd250, rgb);
    n_checks++;
    if (rgb !== 12'h0F0) begin n_errors++; $display("FAIL stalled_published got %h want 0F0", rgb); end
  endtask

  task automatic test_boundary_commit_and_reset();
    logic [11:0] rgb;
    wr(2'd0, 10'd200, 9'd120, 10'd360, 9'd280, 12'hABC, 1'b1, 1'b0);
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    i_commit = 1'b1;
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b0);
    i_commit = 1'b0;
    n_checks++;
    if (o_pending !== 1'b1) begin n_errors++; $display("FAIL boundary_commit_pend got %b want 1", o_pending); end
    step(10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    probe(10'd300, 9'd250, rgb);
    n_checks++;
    if (rgb !== 12'h0F0) begin n_errors++; $display("FAIL boundary_commit_late got %h want 0F0", rgb); end
    frame_edge();
    probe(10'd300, 9'd250, rgb);
    n_checks++;
    if (rgb !== 12'hABC) begin n_errors++; $display("FAIL boundary_commit_applied got %h want ABC", rgb); end
    wr(2'd0, 10'd200, 9'd120, 10'd360, 9'd280, 12'h555, 1'b1, 1'b0);
    commit();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n_checks++;
    if ({o_pending, o_wr_ready, o_r, o_g, o_b} !== {2'b01, 12'h000}) begin
      n_errors++; $display("FAIL reset_pending got pend=%b rdy=%b rgb=%h want 0 1 000",
                           o_pending, o_wr_ready, {o_r, o_g, o_b});
    end
    frame_edge();
    probe(10'd300, 9'd250, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL reset_no_publish got %h want 000", rgb); end
  endtask

  task automatic test_outline();
    logic [11:0] rgb;
    logic [11:0] exp_center;
`ifdef VGA_BOX_OUTLINE_EN
    exp_center = 12'h000;
`else
    exp_center = 12'hF0F;
`endif
    wr(2'd0, 10'd10, 9'd10, 10'd20, 9'd20, 12'hF0F, 1'b1, 1'b1);
    commit();
    frame_edge();
    probe(10'd11, 9'd15, rgb);
    n_checks++;
    if (rgb !== 12'hF0F) begin n_errors++; $display("FAIL outline_left got %h want F0F", rgb); end
    probe(10'd15, 9'd15, rgb);
    n_checks++;
    if (rgb !== exp_center) begin n_errors++; $display("FAIL outline_center got %h want %h", rgb, exp_center); end
    probe(10'd19, 9'd11, rgb);
    n_checks++;
    if (rgb !== 12'hF0F) begin n_errors++; $display("FAIL outline_corner got %h want F0F", rgb); end
    probe(10'd10, 9'd15, rgb);
    n_checks++;
    if (rgb !== 12'h000) begin n_errors++; $display("FAIL outline_outside got %h want 000", rgb); end
  endtask

  initial begin
    test_reset();
    test_commit_single();
    test_latency();
    test_priority();
    test_stall_write();
    test_boundary_commit_and_reset();
    test_outline();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
